// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter: shares the MIG user port among wfc/bfc/dfc/dwc,
// issues burst commands for the owner and counts its data beats.
// Ports: req/req_addr/req_len (per requester), gnt/done one-hot,
// switch/mig_type steering, busy, app_en/app_cmd/app_addr/app_rdy,
// rd_beat/wr_beat beat strobes. clk, rst: sync active-high reset.
// MIG_ARB_RR_EN: round-robin arbitration; undefined = fixed priority.
module mig_port_arbiter #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int LEN_W        = 16,
  parameter int BURST_BYTES  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                req,
  input  logic [4*DDR_ADDR_LEN-1:0] req_addr,
  input  logic [4*LEN_W-1:0]        req_len,
  output logic [3:0]                gnt,
  output logic [3:0]                done,
  output logic [1:0]                switch,
  output logic                      mig_type,
  output logic                      busy,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [DDR_ADDR_LEN-1:0]   app_addr,
  input  logic                      app_rdy,
  input  logic                      rd_beat,
  input  logic                      wr_beat
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  logic [DDR_ADDR_LEN-1:0] base;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        cmd_cnt;
  logic [LEN_W-1:0]        beat_cnt;
  logic [1:0]              owner;

  logic [1:0]              win;
  logic [DDR_ADDR_LEN-1:0] win_addr;
  logic [LEN_W-1:0]        win_len;
  logic [LEN_W-1:0]        cmd_nxt;
  logic                    beat;
  logic                    beat_hit;

`ifdef MIG_ARB_RR_EN
  logic [1:0] ptr;

  // Scan from lowest to highest priority so the
  // first requester after ptr is written last.
  always_comb begin
    win = ptr;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd3;
    end else if (state == IDLE && |req) begin
      ptr <= win;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`endif

  assign win_addr = req_addr[int'(win)*DDR_ADDR_LEN +: DDR_ADDR_LEN];
  assign win_len  = req_len[int'(win)*LEN_W +: LEN_W];
  assign cmd_nxt  = cmd_cnt + 1'b1;

  // Only the owner's direction counts; extra beats saturate at len.
  assign beat     = mig_type ? wr_beat : rd_beat;
  assign beat_hit = beat && (beat_cnt != len);

  assign switch   = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      len      <= '0;
      cmd_cnt  <= '0;
      beat_cnt <= '0;
      owner    <= 2'd0;
      gnt      <= 4'b0;
      done     <= 4'b0;
      mig_type <= 1'b0;
      busy     <= 1'b0;
      app_en   <= 1'b0;
      app_cmd  <= 3'b001;
      app_addr <= '0;
    end else begin
      done <= 4'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            owner    <= win;
            base     <= win_addr;
            len      <= win_len;
            cmd_cnt  <= '0;
            beat_cnt <= '0;
            gnt      <= 4'b1 << win;
            mig_type <= (win == 2'd3);
            app_cmd  <= (win == 2'd3) ? 3'b000 : 3'b001;
            app_addr <= win_addr;
            busy     <= 1'b1;
            // A zero-length grant skips ISSUE; DRAIN then
            // completes at once since beat_cnt == len == 0.
            if (win_len == '0) begin
              app_en <= 1'b0;
              state  <= DRAIN;
            end else begin
              app_en <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (beat_hit) beat_cnt <= beat_cnt + 1'b1;
          if (app_en && app_rdy) begin
            cmd_cnt <= cmd_nxt;
            if (cmd_nxt == len) begin
              app_en <= 1'b0;
              state  <= DRAIN;
            end else begin
              app_addr <= base +
                DDR_ADDR_LEN'(cmd_nxt) *
                DDR_ADDR_LEN'(BURST_BYTES);
            end
          end
        end
        DRAIN: begin
          if (beat_cnt == len) begin
            done  <= gnt;
            gnt   <= 4'b0;
            state <= DONE;
          end else if (beat_hit) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mig_port_arbiter.sv
// tb_mig_port_arbiter: directed scoreboard bench for mig_port_arbiter.
// Expected command addresses and done vectors are queued at request time.
module tb_mig_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_addr;
  logic [63:0]  req_len;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [1:0]   switch;
  logic         mig_type;
  logic         busy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [31:0]  app_addr;
  logic         app_rdy;
  logic         rd_beat;
  logic         wr_beat;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr[$];
  logic [3:0]  done_q[$];
  logic [3:0]  exp_gnt;

`ifdef MIG_ARB_RR_EN
  int arb_seq[4] = '{0, 2, 0, 2};
`else
  int arb_seq[3] = '{0, 0, 0};
`endif

  mig_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .switch   (switch),
    .mig_type (mig_type),
    .busy     (busy),
    .app_en   (app_en),
    .app_cmd  (app_cmd),
    .app_addr (app_addr),
    .app_rdy  (app_rdy),
    .rd_beat  (rd_beat),
    .wr_beat  (wr_beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_switch", switch, 0);
    check("rst_mig_type", mig_type, 0);
    check("rst_busy", busy, 0);
    check("rst_app_en", app_en, 0);
    check("rst_app_cmd", app_cmd, 3'b001);
    check("rst_app_addr", app_addr, 0);
  endtask

  task automatic load(input int r, input logic [31:0] a,
                      input logic [15:0] n);
    req_addr[r*32 +: 32] = a;
    req_len[r*16 +: 16]  = n;
  endtask

  task automatic expect_xfer(input int r, input logic [31:0] a,
                             input logic [15:0] n);
    for (int k = 0; k < int'(n); k++)
      exp_addr.push_back(a + 32'(k * 64));
    done_q.push_back(4'b1 << r);
  endtask

  task automatic grant(input logic [3:0] req_v, input int r,
                       input logic [15:0] n);
    req = req_v;
    tick();
    exp_gnt = 4'b1 << r;
    check("grant_gnt", gnt, exp_gnt);
    check("grant_app_en", app_en, n != 0);
    check("grant_switch", switch, r);
    check("grant_mig_type", mig_type, r == 3);
    check("grant_app_cmd", app_cmd, (r == 3) ? 3'b000 : 3'b001);
    check("grant_busy", busy, 1);
  endtask

  // Drives app_rdy and beats until done; stall_at names the command
  // index held off for stall_n cycles. The other beat line is
  // driven high throughout as noise the owner must ignore.
  task automatic serve(input bit wr, input int n,
                       input int stall_at, input int stall_n);
    int ncmd;
    int nbeat;
    int stalled;
    bit fin;
    ncmd = 0;
    nbeat = 0;
    stalled = 0;
    fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      rd_beat = 1'b0;
      wr_beat = 1'b0;
      app_rdy = 1'b1;
      if (done != 4'b0) begin
        if (done_q.size() == 0) check("done_extra", done, 0);
        else check("done_vec", done, done_q.pop_front());
        check("done_beats", nbeat, n);
        check("done_cmds", ncmd, n);
        check("done_gnt_clr", gnt, 0);
        fin = 1;
      end else begin
        check("xfer_gnt", gnt, exp_gnt);
        if (app_en) begin
          if (exp_addr.size() == 0) check("extra_cmd", app_en, 0);
          else check("cmd_addr", app_addr, exp_addr[0]);
          check("cmd_type", app_cmd, wr ? 3'b000 : 3'b001);
          if (ncmd == stall_at && stalled < stall_n) begin
            app_rdy = 1'b0;
            stalled++;
          end else begin
            ncmd++;
            if (exp_addr.size() != 0) void'(exp_addr.pop_front());
          end
        end
        if (ncmd > 0 && nbeat < n) begin
          nbeat++;
          if (wr) wr_beat = 1'b1;
          else rd_beat = 1'b1;
        end
        if (wr) rd_beat = 1'b1;
        else wr_beat = 1'b1;
      end
      tick();
    end
    rd_beat = 1'b0;
    wr_beat = 1'b0;
    if (!fin) check("done_timeout", fin, 1);
    check("post_done_pulse", done, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    req_addr = '0;
    req_len = '0;
    app_rdy = 1'b0;
    rd_beat = 1'b0;
    wr_beat = 1'b0;
    exp_gnt = 4'b0;
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    tick();

    // Single read, 3 bursts
    load(0, 32'h1000, 3);
    expect_xfer(0, 32'h1000, 3);
    grant(4'b0001, 0, 3);
    req = 4'b0;
    serve(1'b0, 3, -1, 0);

    // Back-pressure on the second command
    expect_xfer(0, 32'h1000, 3);
    grant(4'b0001, 0, 3);
    req = 4'b0;
    serve(1'b0, 3, 1, 2);

    // Write steering
    load(3, 32'h2000, 2);
    expect_xfer(3, 32'h2000, 2);
    grant(4'b1000, 3, 2);
    req = 4'b0;
    serve(1'b1, 2, -1, 0);
    check("hold_switch", switch, 3);
    check("hold_mig_type", mig_type, 1);

    // Address wrap
    load(1, 32'hFFFF_FFC0, 2);
    expect_xfer(1, 32'hFFFF_FFC0, 2);
    grant(4'b0010, 1, 2);
    req = 4'b0;
    serve(1'b0, 2, -1, 0);

    // Zero length: done at t+2, no command
    load(1, 32'h6000, 0);
    expect_xfer(1, 32'h6000, 0);
    grant(4'b0010, 1, 0);
    req = 4'b0;
    tick();
    check("zl_done", done, done_q.pop_front());
    check("zl_app_en", app_en, 0);
    check("zl_gnt", gnt, 0);
    tick();
    check("zl_done_end", done, 0);
    check("zl_busy", busy, 0);

    // Reset after one of four commands
    load(2, 32'h3000, 4);
    grant(4'b0100, 2, 4);
    req = 4'b0;
    check("rm_addr0", app_addr, 32'h3000);
    app_rdy = 1'b1;
    rd_beat = 1'b1;
    tick();
    check("rm_addr1", app_addr, 32'h3040);
    rst = 1'b1;
    rd_beat = 1'b0;
    tick();
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_beat = 1'b1;
      tick();
      check("rm_stray_done", done, 0);
      check("rm_stray_busy", busy, 0);
      check("rm_stray_app_en", app_en, 0);
    end
    rd_beat = 1'b0;
    expect_xfer(2, 32'h3000, 4);
    grant(4'b0100, 2, 4);
    req = 4'b0;
    serve(1'b0, 4, -1, 0);

    // Arbitration with 0 and 2 held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(0, 32'h4000, 1);
    load(2, 32'h5000, 2);
    for (int g = 0; g < $size(arb_seq); g++) begin
      int w;
      w = arb_seq[g];
      if (w == 0) expect_xfer(0, 32'h4000, 1);
      else expect_xfer(2, 32'h5000, 2);
      grant(4'b0101, w, (w == 0) ? 16'd1 : 16'd2);
      if (g == $size(arb_seq) - 1) req = 4'b0;
      serve(1'b0, (w == 0) ? 1 : 2, -1, 0);
    end

    check("sb_addr_empty", exp_addr.size(), 0);
    check("sb_done_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
